uart_bus_loader: RTL

UART-driven bus initiator that drives the same device-bus request interface the CPU uses toward devctrl (enable/write/busy/data/address/byte-select). It parses 5- or 9-byte command packets from the receiver's byte stream, performs one 32-bit read or write per packet, and answers through the transmitter. It lets a host load or inspect RAM, flash, and MMIO without the CPU. Top-level muxes bus ownership with `busActive_o`.

---
 rtl/uart_bus_loader_pkg.sv | 17 +
 rtl/uart_bus_loader_tx_queue.sv | 49 ++++
 rtl/uart_bus_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_bus_loader_pkg.sv
// Shared constants and state encoding for the UART bus loader.
package uart_bus_loader_pkg;

  localparam logic [7:0] CMD_WRITE        = 8'h57;
  localparam logic [7:0] CMD_READ         = 8'h52;
  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEFAULT = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_BUS    = 3'd3,
    ST_TXRESP = 3'd4
  } state_e;

endpackage

// File: rtl/uart_bus_loader_tx_queue.sv
// Up to four reply bytes, shifted out LSB first, with start pulses spaced
// so a late-rising transmitter busy flag is never raced.
module loader_tx_queue (
  input  logic        clk25,
  input  logic        rst,
  input  logic        load_i,
  input  logic [2:0]  load_cnt_i,
  input  logic [31:0] load_data_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output logic [2:0]  count_o
);

  logic [31:0] bytes_q, bytes_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  recent_q, recent_d;

  // recent_q remembers pulses from the previous two cycles
  assign txdStart_o = (count_q != 3'd0) && !txdBusy_i && (recent_q == 2'b00);
  assign txdData_o  = bytes_q[7:0];
  assign count_o    = count_q;

  always_comb begin
    bytes_d  = bytes_q;
    count_d  = count_q;
    recent_d = {recent_q[0], txdStart_o};
    if (load_i) begin
      bytes_d = load_data_i;
      count_d = load_cnt_i;
    end else if (txdStart_o) begin
      bytes_d = {8'h00, bytes_q[31:8]};
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      bytes_q  <= '0;
      count_q  <= '0;
      recent_q <= '0;
    end else begin
      bytes_q  <= bytes_d;
      count_q  <= count_d;
      recent_q <= recent_d;
    end
  end

endmodule

// File: rtl/uart_bus_loader.sv
// UART command parser that performs one 32-bit device-bus read or write per
// packet and answers through the transmitter.
module uart_bus_loader
  import uart_bus_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25000000,
  parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEFAULT,
  parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEFAULT
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output logic        devEnable_o,
  output logic        devWrite_o,
  input  logic        devBusy_i,
  output logic [31:0] devDataSave_o,
  input  logic [31:0] devDataLoad_i,
  output logic [31:0] devPhysicalAddr_o,
  output logic [3:0]  devByteSelect_o,
  output logic        busActive_o
);

  localparam logic [31:0] GAP_LIMIT = 32'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] gap_q, gap_d;
  logic        is_write_q, is_write_d;

  logic        q_load;
  logic [2:0]  q_load_cnt;
  logic [31:0] q_load_data;
  logic [2:0]  q_count;
  logic        q_start;
  logic        bus_en;

  loader_tx_queue u_tx_queue (
    .clk25       (clk25),
    .rst         (rst),
    .load_i      (q_load),
    .load_cnt_i  (q_load_cnt),
    .load_data_i (q_load_data),
    .txdBusy_i   (txdBusy_i),
    .txdStart_o  (q_start),
    .txdData_o   (txdData_o),
    .count_o     (q_count)
  );

  assign txdStart_o = q_start;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    is_write_d  = is_write_q;
    gap_d       = '0;
    q_load      = 1'b0;
    q_load_cnt  = 3'd0;
    q_load_data = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 2'd0;
        if (rxdReady_i) begin
          if (rxdData_i == CMD_WRITE || rxdData_i == CMD_READ) begin
            is_write_d = (rxdData_i == CMD_WRITE);
            state_d    = ST_ADDR;
          end else begin
            q_load      = 1'b1;
            q_load_cnt  = 3'd1;
            q_load_data = {24'h0, NAK_BYTE};
            state_d     = ST_TXRESP;
          end
        end
      end
      ST_ADDR, ST_DATA: begin
        if (rxdReady_i) begin
          if (state_q == ST_ADDR) begin
            addr_d[{cnt_q, 3'b000} +: 8] = rxdData_i;
          end else begin
            data_d[{cnt_q, 3'b000} +: 8] = rxdData_i;
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = (state_q == ST_ADDR && is_write_q) ? ST_DATA : ST_BUS;
          end
        end else if (gap_q == GAP_LIMIT) begin
          // host went quiet mid-packet: drop it silently
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      ST_BUS: begin
        if (!devBusy_i) begin
          q_load      = 1'b1;
          q_load_cnt  = is_write_q ? 3'd1 : 3'd4;
          q_load_data = is_write_q ? {24'h0, ACK_BYTE} : devDataLoad_i;
          state_d     = ST_TXRESP;
        end
      end
      ST_TXRESP: begin
        if ((q_start && q_count == 3'd1) || q_count == 3'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      gap_q      <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      gap_q      <= gap_d;
      is_write_q <= is_write_d;
    end
  end

  // Request outputs are zero outside BUS so the top-level mux sees a clean bus
  assign bus_en            = (state_q == ST_BUS);
  assign devEnable_o       = bus_en;
  assign devWrite_o        = bus_en && is_write_q;
  assign devPhysicalAddr_o = bus_en ? addr_q : 32'h0;
  assign devDataSave_o     = (bus_en && is_write_q) ? data_q : 32'h0;
  assign devByteSelect_o   = bus_en ? 4'hf : 4'h0;
  assign busActive_o       = (state_q == ST_ADDR) || (state_q == ST_DATA) || bus_en;

endmodule
